instruction_fetch_unit: RTL and testbench

- Fetch stage directly downstream of the instruction address generator.
- Takes the current PC and runs a single-outstanding read handshake with instruction memory.
- Latches the returned word into the instruction register (IR) and pulses PC_enable back to the address generator so PC advances exactly once per completed fetch.
- Reports misaligned-PC and memory-timeout faults to the control unit.

---
 rtl/instruction_fetch_unit.sv | 117 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: runs one outstanding read per fetch, latches the word into IR
// and pulses PC_enable once per completed fetch; reports misaligned/timeout faults.
module instruction_fetch_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] PC,
  input  logic              Fetch_req,
  input  logic              Stall,
  input  logic              IR_ack,
  input  logic              Fault_clr,
  input  logic              Mem_ready,
  input  logic [DATA_W-1:0] Mem_data,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic              Mem_read,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] IR_PC,
  output logic              IR_valid,
  output logic              PC_enable,
  output logic              Busy,
  output logic              Misaligned,
  output logic              Timeout,
  output logic [CNT_W-1:0]  Fetch_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    VALID    = 2'd2,
    FAULT    = 2'd3
  } fetchState_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  fetchState_t state;
  logic [7:0]  waitCnt;

  // PC_enable is cleared every cycle by default so it can only ever be a
  // single-cycle pulse, raised on the WAIT->VALID transition.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      waitCnt     <= '0;
      Mem_addr    <= '0;
      Mem_read    <= 1'b0;
      IR          <= '0;
      IR_PC       <= '0;
      IR_valid    <= 1'b0;
      PC_enable   <= 1'b0;
      Busy        <= 1'b0;
      Misaligned  <= 1'b0;
      Timeout     <= 1'b0;
      Fetch_count <= '0;
    end else begin
      PC_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (Fetch_req && !Stall) begin
            if (PC[1:0] == 2'b00) begin
              Mem_addr <= PC;
              IR_PC    <= PC;
              Mem_read <= 1'b1;
              Busy     <= 1'b1;
              waitCnt  <= '0;
              state    <= WAIT_MEM;
            end else begin
              Misaligned <= 1'b1;
              state      <= FAULT;
            end
          end
        end

        WAIT_MEM: begin
          if (Mem_ready) begin
            IR          <= Mem_data;
            IR_valid    <= 1'b1;
            Mem_read    <= 1'b0;
            Busy        <= 1'b0;
            PC_enable   <= 1'b1;
            Fetch_count <= Fetch_count + 1'b1;
            state       <= VALID;
          end else if (waitCnt == TIMEOUT_LAST) begin
            // Give up without PC_enable so PC stays on the faulting address.
            Mem_read <= 1'b0;
            Busy     <= 1'b0;
            Timeout  <= 1'b1;
            state    <= FAULT;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end

        VALID: begin
          if (IR_ack) begin
            IR_valid <= 1'b0;
            state    <= IDLE;
          end
        end

        FAULT: begin
          if (Fault_clr) begin
            Misaligned <= 1'b0;
            Timeout    <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: table-driven fetches checked through a
// scoreboard on PC_enable, plus hand sequences for stall/fault/reset/wrap cases.
module tb_instruction_fetch_unit;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;

  logic              Clock = 1'b0;
  logic              Reset_n;
  logic [ADDR_W-1:0] PC;
  logic              Fetch_req, Stall, IR_ack, Fault_clr, Mem_ready;
  logic [DATA_W-1:0] Mem_data;
  logic [ADDR_W-1:0] Mem_addr;
  logic              Mem_read;
  logic [DATA_W-1:0] IR;
  logic [ADDR_W-1:0] IR_PC;
  logic              IR_valid, PC_enable, Busy, Misaligned, Timeout;
  logic [CNT_W-1:0]  Fetch_count;

  instruction_fetch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .PC(PC), .Fetch_req(Fetch_req),
    .Stall(Stall), .IR_ack(IR_ack), .Fault_clr(Fault_clr),
    .Mem_ready(Mem_ready), .Mem_data(Mem_data), .Mem_addr(Mem_addr),
    .Mem_read(Mem_read), .IR(IR), .IR_PC(IR_PC), .IR_valid(IR_valid),
    .PC_enable(PC_enable), .Busy(Busy), .Misaligned(Misaligned),
    .Timeout(Timeout), .Fetch_count(Fetch_count)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] irPc;
    logic [31:0] cnt;
  } expect_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          latency;
    int          ackDelay;
    int          preStall;
    bit          stallInWait;
    logic [31:0] expIr;
    logic [31:0] expIrPc;
  } fetchVec_t;

  expect_t     sbQueue[$];
  expect_t     sbHead;
  fetchVec_t   vecs[5];
  int          nApplied = 0;
  int          nMiscompare = 0;
  logic [CNT_W-1:0] expCount = '0;
  logic [31:0] lastIr = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiscompare++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every completed fetch must match the oldest pending expectation.
  always @(negedge Clock) begin
    if (Reset_n && PC_enable) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpectedPulse", 32'(PC_enable), 32'd0);
      end else begin
        sbHead = sbQueue.pop_front();
        checkOutput("sbIR", IR, sbHead.ir);
        checkOutput("sbIR_PC", IR_PC, sbHead.irPc);
        checkOutput("sbCount", 32'(Fetch_count), sbHead.cnt);
      end
    end
  end

  task automatic pushExpect(input logic [31:0] ir, input logic [31:0] pc);
    expect_t e;
    expCount = expCount + 1'b1;
    e.ir   = ir;
    e.irPc = pc;
    e.cnt  = 32'(expCount);
    sbQueue.push_back(e);
    lastIr = ir;
  endtask

  task automatic applyStimulus(input fetchVec_t v);
    bit seen;
    PC        = v.pc;
    Fetch_req = 1'b1;
    Stall     = (v.preStall > 0);
    for (int i = 0; i < v.preStall; i++) begin
      @(negedge Clock);
      checkOutput("stallNoRead", 32'(Mem_read), 32'd0);
    end
    Stall = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge Clock);
      seen = Mem_read;
    end
    checkOutput("readStart", 32'(seen), 32'd1);
    if (!seen) begin
      Fetch_req = 1'b0;
      return;
    end
    checkOutput("memAddr", Mem_addr, v.pc);
    checkOutput("busyWait", 32'(Busy), 32'd1);
    Fetch_req = 1'b0;
    Stall     = v.stallInWait;
    for (int i = 0; i < v.latency; i++) begin
      @(negedge Clock);
      checkOutput("readHeld", 32'(Mem_read), 32'd1);
    end
    Mem_ready = 1'b1;
    Mem_data  = v.data;
    pushExpect(v.expIr, v.expIrPc);
    @(negedge Clock);
    Mem_ready = 1'b0;
    Mem_data  = 32'h5A5A_5A5A;
    Stall     = 1'b0;
    checkOutput("pulse", 32'(PC_enable), 32'd1);
    checkOutput("irValid", 32'(IR_valid), 32'd1);
    checkOutput("readDrop", 32'(Mem_read), 32'd0);
    checkOutput("busyDrop", 32'(Busy), 32'd0);
    for (int i = 0; i < v.ackDelay; i++) begin
      @(negedge Clock);
      checkOutput("pulseOnce", 32'(PC_enable), 32'd0);
      checkOutput("irHeld", IR, v.expIr);
      checkOutput("irValidHeld", 32'(IR_valid), 32'd1);
    end
    IR_ack = 1'b1;
    @(negedge Clock);
    IR_ack = 1'b0;
    checkOutput("irConsumed", 32'(IR_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    int lastCyc;
    int readCycles;

    vecs[0] = '{32'h0000_0010, 32'h8C22_0004, 2, 1, 0, 1'b0, 32'h8C22_0004, 32'h0000_0010};
    vecs[1] = '{32'h0000_0100, 32'h1234_5678, 0, 0, 0, 1'b0, 32'h1234_5678, 32'h0000_0100};
    vecs[2] = '{32'h0000_0040, 32'hCAFE_F00D, 1, 0, 3, 1'b0, 32'hCAFE_F00D, 32'h0000_0040};
    vecs[3] = '{32'hFFFF_FFFC, 32'h0BAD_BEEF, 3, 2, 0, 1'b1, 32'h0BAD_BEEF, 32'hFFFF_FFFC};
    vecs[4] = '{32'h0000_2008, 32'hFFFF_0000, 5, 3, 1, 1'b1, 32'hFFFF_0000, 32'h0000_2008};

    Reset_n = 1'b0; PC = '0; Fetch_req = 0; Stall = 0; IR_ack = 0;
    Fault_clr = 0; Mem_ready = 0; Mem_data = '0;
    #12;
    checkOutput("rstMemRead", 32'(Mem_read), 32'd0);
    checkOutput("rstIrValid", 32'(IR_valid), 32'd0);
    checkOutput("rstCount", 32'(Fetch_count), 32'd0);
    checkOutput("rstIR", IR, 32'd0);
    checkOutput("rstFaults", {30'd0, Misaligned, Timeout}, 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);
    checkOutput("countAfterTable", 32'(Fetch_count), 32'd5);

    // Back-to-back: generator bumps PC on each pulse, ack and ready held high.
    PC = 32'h0; Mem_ready = 1'b1; IR_ack = 1'b1;
    Mem_data = 32'hA000_0000 | PC;
    for (int k = 0; k < 3; k++) pushExpect(32'hA000_0000 | 32'(4 * k), 32'(4 * k));
    Fetch_req = 1'b1;
    pulses = 0; lastCyc = 0;
    for (int c = 0; c < 30 && pulses < 3; c++) begin
      @(negedge Clock);
      if (PC_enable) begin
        pulses++;
        if (pulses > 1) checkOutput("b2bPeriod", 32'(c - lastCyc), 32'd3);
        lastCyc = c;
        PC = PC + 32'd4;
        Mem_data = 32'hA000_0000 | PC;
        if (pulses == 3) Fetch_req = 1'b0;
      end
    end
    checkOutput("b2bPulses", 32'(pulses), 32'd3);
    @(negedge Clock);
    IR_ack = 1'b0; Mem_ready = 1'b0;
    checkOutput("b2bDone", 32'(IR_valid), 32'd0);
    checkOutput("b2bCount", 32'(Fetch_count), 32'd8);
    @(negedge Clock);
    checkOutput("b2bNoRefetch", 32'(Mem_read), 32'd0);

    // Misaligned PC, then Fault_clr with Fetch_req still high.
    PC = 32'h0000_0006; Fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      checkOutput("misFlag", 32'(Misaligned), 32'd1);
      checkOutput("misNoRead", 32'(Mem_read), 32'd0);
    end
    Fault_clr = 1'b1;
    @(negedge Clock);
    Fault_clr = 1'b0; Fetch_req = 1'b0;
    checkOutput("misCleared", 32'(Misaligned), 32'd0);
    checkOutput("clrPriority", 32'(Mem_read), 32'd0);
    @(negedge Clock);
    checkOutput("misIdle", 32'(Mem_read), 32'd0);

    // Timeout: memory never answers.
    PC = 32'h0000_0020; Fetch_req = 1'b1;
    @(negedge Clock);
    Fetch_req = 1'b0;
    readCycles = 0;
    for (int i = 0; i < 40 && Mem_read; i++) begin
      readCycles++;
      @(negedge Clock);
    end
    checkOutput("toReadCycles", 32'(readCycles), 32'd15);
    checkOutput("toFlag", 32'(Timeout), 32'd1);
    checkOutput("toIrValid", 32'(IR_valid), 32'd0);
    Mem_ready = 1'b1; Mem_data = 32'hDEAD_BEEF;
    @(negedge Clock);
    Mem_ready = 1'b0;
    checkOutput("lateReadyIR", IR, lastIr);
    checkOutput("lateReadyCount", 32'(Fetch_count), 32'(expCount));
    checkOutput("toHeld", 32'(Timeout), 32'd1);
    Fault_clr = 1'b1;
    @(negedge Clock);
    Fault_clr = 1'b0;
    checkOutput("toCleared", 32'(Timeout), 32'd0);

    // Reset asserted mid-WAIT takes effect without a clock edge.
    PC = 32'h0000_0080; Fetch_req = 1'b1;
    @(negedge Clock);
    Fetch_req = 1'b0;
    checkOutput("preRstRead", 32'(Mem_read), 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("asyncRead", 32'(Mem_read), 32'd0);
    checkOutput("asyncBusy", 32'(Busy), 32'd0);
    checkOutput("asyncIrValid", 32'(IR_valid), 32'd0);
    checkOutput("asyncCount", 32'(Fetch_count), 32'd0);
    sbQueue.delete();
    expCount = '0;
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    applyStimulus(vecs[0]);

    // Counter wrap: 17 fetches total since reset on a 4-bit counter.
    for (int i = 1; i < 17; i++) applyStimulus(vecs[i % 5]);
    checkOutput("wrapCount", 32'(Fetch_count), 32'd1);
    checkOutput("sbDrained", 32'(sbQueue.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
    $finish;
  end

endmodule
